branch_resolve_unit: RTL

Execute-stage companion to the bimodal branch predictor. It records each fetched instruction's PC and predicted next PC in a small in-order FIFO, and compares the actual control-flow outcome against that record when the instruction resolves in execute. It drives the predictor's update port (`we`/`PCUpdate`/`targetUpdate`/`takenUpdate`) and issues a one-cycle pipeline redirect/flush on misprediction. Mispredict statistics are kept for performance analysis.

---
 rtl/branch_resolve_unit_pkg.sv | 39 +++
 rtl/branch_resolve_unit_fifo.sv | 62 ++++++
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared types and constants for the execute-stage branch resolve unit.
//   DataBusBits : width of PCs and targets (mirrors the core's data bus width)
//   BrCntBits   : width of branch statistics counters (shared with perf CSRs)
//   brs_state_e : resolve FSM states
//   bp_entry_t  : one in-flight prediction record {pc, pred}
//   actual_next_pc() : architectural next PC of a resolved instruction
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam int DataBusBits = 64;
    localparam int BrCntBits   = 32;

    localparam logic ST_NORMAL_ENC = 1'b0;
    localparam logic ST_FLUSH_ENC  = 1'b1;

    typedef enum logic {
        ST_NORMAL = ST_NORMAL_ENC,
        ST_FLUSH  = ST_FLUSH_ENC
    } brs_state_e;

    typedef struct packed {
        logic [DataBusBits-1:0] pc;
        logic [DataBusBits-1:0] pred;
    } bp_entry_t;

    // Taken control flow goes to the resolved target; everything else falls
    // through to pc+4 (the caller supplies the wrapped 64-bit sum).
    function automatic logic [DataBusBits-1:0] actual_next_pc(
        input logic                   ctrl,
        input logic                   taken,
        input logic [DataBusBits-1:0] pc_plus4,
        input logic [DataBusBits-1:0] target
    );
        return (ctrl && taken) ? target : pc_plus4;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// -----------------------------------------------------------------------------
// branch_pred_fifo
// In-order queue of {pc, pred} records for fetched, not yet resolved
// instructions.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_entry: enqueue at tail (dropped when full unless popping too)
//   i_pop          : dequeue head (ignored when empty)
//   i_clear        : empty the queue at the end of this cycle
//   o_head         : record at head
//   o_full, o_empty: occupancy flags, combinational from the count
// -----------------------------------------------------------------------------
module branch_pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_push,
    input  bp_entry_t i_entry,
    input  logic      i_pop,
    input  logic      i_clear,
    output bp_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int PW = $clog2(DEPTH);

    bp_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Checks each resolving instruction against the prediction recorded at fetch,
// updates the bimodal predictor and redirects fetch on a mispredict.
//   clk, reset                  : clock, synchronous active-high reset
//   push_valid/push_pc/push_pred: fetch-side record of PC and predicted next PC
//   full                        : queue holds DEPTH records, fetch must stall
//   res_valid/res_pc/res_ctrl/res_taken/res_target : execute-side outcome
//   upd_we/upd_pc/upd_target/upd_taken : registered predictor update port
//   redirect/redirect_pc        : one-cycle flush and correct next PC
//   sync_error                  : sticky fetch/execute protocol violation
//   branch_count/mispredict_count : saturating statistics
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = BrCntBits
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [DataBusBits-1:0] push_pc,
    input  logic [DataBusBits-1:0] push_pred,
    output logic                   full,
    input  logic                   res_valid,
    input  logic [DataBusBits-1:0] res_pc,
    input  logic                   res_ctrl,
    input  logic                   res_taken,
    input  logic [DataBusBits-1:0] res_target,
    output logic                   upd_we,
    output logic [DataBusBits-1:0] upd_pc,
    output logic [DataBusBits-1:0] upd_target,
    output logic                   upd_taken,
    output logic                   redirect,
    output logic [DataBusBits-1:0] redirect_pc,
    output logic                   sync_error,
    output logic [CNT_BITS-1:0]    branch_count,
    output logic [CNT_BITS-1:0]    mispredict_count
);
    brs_state_e             r_state;
    logic                   r_upd_we;
    logic [DataBusBits-1:0] r_upd_pc;
    logic [DataBusBits-1:0] r_upd_target;
    logic                   r_upd_taken;
    logic                   r_redirect;
    logic [DataBusBits-1:0] r_redirect_pc;
    logic                   r_sync_error;
    logic [CNT_BITS-1:0]    r_branch_count;
    logic [CNT_BITS-1:0]    r_mispredict_count;

    bp_entry_t              w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_normal;
    logic                   w_push;
    logic                   w_resolve;
    logic                   w_mispredict;
    logic                   w_ctrl_upd;
    logic                   w_err;
    logic [DataBusBits-1:0] w_pc_plus4;
    logic [DataBusBits-1:0] w_actual;

    // During FLUSH every fetch/execute input belongs to the wrong path.
    assign w_normal     = (r_state == ST_NORMAL);
    assign w_push       = w_normal & push_valid;
    assign w_resolve    = w_normal & res_valid & ~w_empty;
    assign w_pc_plus4   = res_pc + DataBusBits'(4);
    assign w_actual     = actual_next_pc(res_ctrl, res_taken, w_pc_plus4, res_target);
    assign w_mispredict = w_resolve & (w_actual != w_head.pred);
    assign w_ctrl_upd   = w_resolve & res_ctrl;

    // Resolve on empty, head PC mismatch, or a push dropped by a full queue.
    assign w_err = w_normal & ((res_valid & w_empty)
                             | (w_resolve & (res_pc != w_head.pc))
                             | (push_valid & w_full & ~res_valid));

    branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_entry ('{pc: push_pc, pred: push_pred}),
        .i_pop   (w_resolve),
        .i_clear (r_state == ST_FLUSH),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_NORMAL;
            r_upd_we           <= 1'b0;
            r_upd_pc           <= '0;
            r_upd_target       <= '0;
            r_upd_taken        <= 1'b0;
            r_redirect         <= 1'b0;
            r_redirect_pc      <= '0;
            r_sync_error       <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            case (r_state)
                ST_NORMAL: r_state <= w_mispredict ? ST_FLUSH : ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase
            r_upd_we   <= w_ctrl_upd;
            r_redirect <= w_mispredict;
            if (w_ctrl_upd) begin
                r_upd_pc     <= res_pc;
                r_upd_target <= res_target;
                r_upd_taken  <= res_taken;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_actual;
            end
            if (w_err) begin
                r_sync_error <= 1'b1;
            end
            if (w_ctrl_upd && (r_branch_count != '1)) begin
                r_branch_count <= r_branch_count + CNT_BITS'(1);
            end
            if (w_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_BITS'(1);
            end
        end
    end

    assign full             = w_full;
    assign upd_we           = r_upd_we;
    assign upd_pc           = r_upd_pc;
    assign upd_target       = r_upd_target;
    assign upd_taken        = r_upd_taken;
    assign redirect         = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign sync_error       = r_sync_error;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
